// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths and requester IDs for the CDB arbiter.
package cdb_arbiter_pkg;
  localparam int Reg_Lock_Width = 5;
  localparam int Data_Width = 32;
  localparam int Num_Req = 3;
  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_BRA = 2'd1,
    REQ_LSU = 2'd2
  } req_id_e;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// cdb_arbiter_rr_picker: combinational round-robin priority encoder starting at i_ptr.
module cdb_arbiter_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int SRC_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_winner,
  output logic               o_any
);
  always_comb begin
    o_grant = '0;
    o_winner = '0;
    // Scan farthest-first so the request closest to i_ptr is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_winner = SRC_W'((int'(i_ptr) + k) % NUM_REQ);
        o_grant = NUM_REQ'(1) << ((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit one-entry result buffers arbitrated round-robin onto a
// registered common data bus broadcast, with misprediction flush.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = Num_Req,
  parameter int IDX_W = Reg_Lock_Width,
  parameter int DATA_W = Data_Width
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]    i_req_index,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_result,
  output logic                        o_cdb_valid,
  output logic [IDX_W-1:0]            o_cdb_index,
  output logic [DATA_W-1:0]           o_cdb_result,
  output logic [$clog2(NUM_REQ)-1:0]  o_cdb_src
);
  localparam int SRC_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] r_buf_valid;
  logic [IDX_W-1:0]   r_buf_index [NUM_REQ];
  logic [DATA_W-1:0]  r_buf_result [NUM_REQ];
  logic [SRC_W-1:0]   r_rr_ptr;
  logic               r_cdb_valid;
  logic [IDX_W-1:0]   r_cdb_index;
  logic [DATA_W-1:0]  r_cdb_result;
  logic [SRC_W-1:0]   r_cdb_src;
  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_winner;
  logic               w_any;

  cdb_arbiter_rr_picker #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_picker (
    .i_req    (r_buf_valid),
    .i_ptr    (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // A granted buffer drains this edge, so it can accept a refill in the same cycle.
  assign o_req_ready = {NUM_REQ{!i_flush}} & (~r_buf_valid | w_grant);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf_valid <= '0;
      r_rr_ptr <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_index <= '0;
      r_cdb_result <= '0;
      r_cdb_src <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_buf_index[i] <= '0;
        r_buf_result[i] <= '0;
      end
    end else if (i_flush) begin
      r_buf_valid <= '0;
      r_cdb_valid <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_req_valid[i] && o_req_ready[i]) begin
          r_buf_valid[i] <= 1'b1;
          r_buf_index[i] <= i_req_index[i*IDX_W +: IDX_W];
          r_buf_result[i] <= i_req_result[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_index <= r_buf_index[w_winner];
        r_cdb_result <= r_buf_result[w_winner];
        r_cdb_src <= w_winner;
        r_rr_ptr <= (w_winner == SRC_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
    end
  end

  assign o_cdb_valid = r_cdb_valid;
  assign o_cdb_index = r_cdb_index;
  assign o_cdb_result = r_cdb_result;
  assign o_cdb_src = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenario tasks with hand-computed expectations for cdb_arbiter.
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [14:0] req_index = '0;
  logic [95:0] req_result = '0;
  logic        cdb_valid;
  logic [4:0]  cdb_index;
  logic [31:0] cdb_result;
  logic [1:0]  cdb_src;
  logic [39:0] bus;
  int checks = 0;
  int failures = 0;

  assign bus = {cdb_valid, cdb_src, cdb_index, cdb_result};
  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(3), .IDX_W(5), .DATA_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_index  (req_index),
    .i_req_result (req_result),
    .o_cdb_valid  (cdb_valid),
    .o_cdb_index  (cdb_index),
    .o_cdb_result (cdb_result),
    .o_cdb_src    (cdb_src)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] idx, input logic [31:0] res);
    req_index[i*5 +: 5] = idx;
    req_result[i*32 +: 32] = res;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    req_valid = '0;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    #2;
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", req_ready); end
    checks++; if (bus !== 40'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", bus); end
    step();
    step();
    checks++; if (bus !== 40'h0) begin failures++; $display("FAIL reset_hold got=%h exp=0", bus); end
    rst_n = 1'b1;
    req_valid = 3'b001;
    set_req(0, 5'd5, 32'hAA);
    step();
    req_valid = '0;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_latency1 got=%b exp=0", cdb_valid); end
    step();
    checks++; if (bus !== {1'b1, 2'd0, 5'd5, 32'hAA}) begin failures++; $display("FAIL reset_first got=%h exp=%h", bus, {1'b1, 2'd0, 5'd5, 32'hAA}); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_contention();
    do_flush();
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h101);
    set_req(1, 5'd2, 32'h102);
    set_req(2, 5'd3, 32'h103);
    #1;
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL cont_ready_empty got=%b exp=111", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if ({req_ready, cdb_valid} !== 4'b0010) begin failures++; $display("FAIL cont_loaded got=%b exp=0010", {req_ready, cdb_valid}); end
    step();
    checks++; if (bus !== {1'b1, 2'd0, 5'd1, 32'h101}) begin failures++; $display("FAIL cont_src0 got=%h exp=%h", bus, {1'b1, 2'd0, 5'd1, 32'h101}); end
    checks++; if (req_ready !== 3'b011) begin failures++; $display("FAIL cont_ready1 got=%b exp=011", req_ready); end
    step();
    checks++; if (bus !== {1'b1, 2'd1, 5'd2, 32'h102}) begin failures++; $display("FAIL cont_src1 got=%h exp=%h", bus, {1'b1, 2'd1, 5'd2, 32'h102}); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL cont_ready2 got=%b exp=111", req_ready); end
    step();
    checks++; if (bus !== {1'b1, 2'd2, 5'd3, 32'h103}) begin failures++; $display("FAIL cont_src2 got=%h exp=%h", bus, {1'b1, 2'd2, 5'd3, 32'h103}); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL cont_idle got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_fairness();
    int cnt[3];
    logic [1:0] e;
    cnt = '{0, 0, 0};
    do_flush();
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) set_req(i, 5'(8 + i), 32'(32'h200 + i));
    step();
    for (int k = 0; k < 30; k++) begin
      step();
      e = 2'(k % 3);
      checks++; if ({cdb_valid, cdb_src, cdb_index} !== {1'b1, e, 5'd8 + 5'(e)}) begin failures++; $display("FAIL fair_rotate cycle=%0d got=%b exp=%b", k, {cdb_valid, cdb_src, cdb_index}, {1'b1, e, 5'd8 + 5'(e)}); end
      if (cdb_valid && cdb_src < 2'd3) cnt[cdb_src]++;
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cnt[i] !== 10) begin failures++; $display("FAIL fair_count src=%0d got=%0d exp=10", i, cnt[i]); end
    end
  endtask

  task automatic test_streaming();
    do_flush();
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        req_valid = 3'b001;
        set_req(0, 5'(k), 32'(32'h300 + k));
        #1;
        checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, req_ready[0]); end
      end else begin
        req_valid = '0;
      end
      step();
      if (k >= 1 && k <= 16) begin
        checks++; if (bus !== {1'b1, 2'd0, 5'(k - 1), 32'(32'h300 + k - 1)}) begin failures++; $display("FAIL stream_bus k=%0d got=%h exp=%h", k, bus, {1'b1, 2'd0, 5'(k - 1), 32'(32'h300 + k - 1)}); end
      end else begin
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL stream_idle k=%0d got=%b exp=0", k, cdb_valid); end
      end
    end
  endtask

  task automatic test_flush();
    do_flush();
    req_valid = 3'b111;
    set_req(0, 5'd4, 32'h400);
    set_req(1, 5'd6, 32'h401);
    set_req(2, 5'd7, 32'h402);
    step();
    req_valid = '0;
    step();
    checks++; if ({cdb_valid, cdb_src} !== 3'b100) begin failures++; $display("FAIL flush_pre got=%b exp=100", {cdb_valid, cdb_src}); end
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL flush_ready got=%b exp=000", req_ready); end
    step();
    flush = 1'b0;
    #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_cdb got=%b exp=0", cdb_valid); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL flush_empty got=%b exp=111", req_ready); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_stale k=%0d got=%b exp=0", k, cdb_valid); end
    end
    req_valid = 3'b101;
    set_req(0, 5'd9, 32'h409);
    set_req(2, 5'd10, 32'h40A);
    step();
    req_valid = '0;
    step();
    checks++; if (bus !== {1'b1, 2'd0, 5'd9, 32'h409}) begin failures++; $display("FAIL flush_ptr_first got=%h exp=%h", bus, {1'b1, 2'd0, 5'd9, 32'h409}); end
    step();
    checks++; if (bus !== {1'b1, 2'd2, 5'd10, 32'h40A}) begin failures++; $display("FAIL flush_ptr_second got=%h exp=%h", bus, {1'b1, 2'd2, 5'd10, 32'h40A}); end
    req_valid = 3'b100;
    set_req(2, 5'd11, 32'h40B);
    step();
    req_valid = '0;
    step();
    checks++; if (bus !== {1'b1, 2'd2, 5'd11, 32'h40B}) begin failures++; $display("FAIL flush_req2 got=%h exp=%h", bus, {1'b1, 2'd2, 5'd11, 32'h40B}); end
  endtask

  task automatic test_async_reset();
    do_flush();
    req_valid = 3'b111;
    set_req(0, 5'd12, 32'h500);
    set_req(1, 5'd13, 32'h501);
    set_req(2, 5'd14, 32'h502);
    step();
    req_valid = '0;
    step();
    checks++; if ({cdb_valid, cdb_src} !== 3'b100) begin failures++; $display("FAIL arst_pre got=%b exp=100", {cdb_valid, cdb_src}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus !== 40'h0) begin failures++; $display("FAIL arst_immediate got=%h exp=0", bus); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL arst_ready got=%b exp=111", req_ready); end
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL arst_no_replay k=%0d got=%b exp=0", k, cdb_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fairness();
    test_streaming();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the result-producing functional units: ALU, Branch_ALU and the future load unit. Each unit hands one result (ROB entry index plus data) into a one-entry holding buffer through a valid/ready handshake. A round-robin arbiter picks one buffered result per cycle and drives a registered broadcast consumed by the ROB, the reservation stations and the PC. A flush input discards every in-flight result on a branch misprediction.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (0 = ALU, 1 = Branch_ALU, 2 = load)
- IDX_W, 5, ROB entry / reg-lock index width
- DATA_W, 32, result width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-low
- flush  in  1  ROB misprediction flush
- req_valid  in  NUM_REQ  per-requester result valid
- req_ready  out  NUM_REQ  per-requester accept
- req_index  in  NUM_REQ*IDX_W  flattened indices; requester i occupies bits [i*IDX_W +: IDX_W]
- req_result  in  NUM_REQ*DATA_W  flattened results; requester i occupies bits [i*DATA_W +: DATA_W]
- cdb_valid  out  1  broadcast valid (registered)
- cdb_index  out  IDX_W  broadcast ROB entry (registered)
- cdb_result  out  DATA_W  broadcast data (registered)
- cdb_src  out  $clog2(NUM_REQ)  requester that won the broadcast, for debug and stats

## Operation
- Each requester has one buffer holding buf_valid, buf_index and buf_result.
- req_ready[i] = !flush && (!buf_valid[i] || grant[i]). This path is combinational from the buffer state and the grant.
- A transfer occurs when req_valid[i] && req_ready[i]. The buffer loads index and result, and buf_valid stays 1.
- Grant selection is combinational: grant is the first i with buf_valid[i] set, searching from rr_ptr upward modulo NUM_REQ. At most one grant per cycle.
- On a grant of winner w:
  - cdb_valid <= 1, cdb_index <= buf_index[w], cdb_result <= buf_result[w], cdb_src <= w.
  - buf_valid[w] clears unless refilled in the same cycle.
  - rr_ptr <= (w+1) mod NUM_REQ.
- With no buffer valid: cdb_valid <= 0, cdb_index and cdb_result hold their previous values, and rr_ptr is unchanged.
- flush = 1:
  - All buf_valid <= 0 and cdb_valid <= 0.
  - No grant and no accept that cycle.
  - rr_ptr <= 0.
  - Flush overrides every other event.
- Reset (rst = 0): all buf_valid = 0, cdb_valid = 0, cdb_index = 0, cdb_result = 0, cdb_src = 0, rr_ptr = 0. Outputs take these values immediately, without waiting for a clock edge.
- Reset deasserting mid-operation leaves the block idle. No replay of lost results.

## Timing
- Latency from accept at edge t to cdb_valid is 2 edges when uncontended: the buffer loads at edge t, and the grant registers at edge t+1.
- Sustained throughput is one result per cycle per requester when that requester is the only one active, because a granted buffer refills in the same cycle.
- Under full contention each requester gets 1 grant per NUM_REQ cycles. Its req_ready is low while its buffer is full and not granted.
- Requesters must hold req_valid, req_index and req_result stable until the handshake completes. The arbiter never drops an accepted result except on flush or reset.
- cdb_valid is a single-cycle pulse per result. There is no backpressure from consumers.

## Structure
- Shared package / defines header: IDX_W maps to `Reg_Lock_Width`, DATA_W maps to `Data_Width`, and the requester ID constants REQ_ALU=0, REQ_BRA=1, REQ_LSU=2.
- One sub-module, rr_picker: a combinational round-robin priority encoder with inputs req[NUM_REQ] and ptr, and outputs grant one-hot, winner index and any.
- The top holds the buffers, output registers and rr_ptr.

## Test plan
- Reset check: hold rst = 0, drive all req_valid = 1. Expect cdb_valid = 0, req_ready = 3'b111, and all outputs 0. Release rst, then accept ALU {index 5, result 0x0000_00AA}. Expect cdb_valid for exactly 1 cycle, 2 edges later, with index 5, result 0xAA, src 0.
- Contention: all three requesters deliver simultaneously (indices 1, 2, 3). Expect broadcasts in order src 0, 1, 2 on consecutive cycles. Expect req_ready[1] = 0 and req_ready[2] = 0 until each is granted.
- Fairness: hold req_valid = 3'b111 continuously with fresh data every accept. Over 30 cycles expect exactly 10 grants per requester, rotating 0, 1, 2.
- Streaming: ALU alone, valid every cycle, indices 0 to 15. Expect 16 back-to-back cdb_valid cycles with no gaps and req_ready[0] constantly 1.
- Flush: buffers 1 and 2 full and cdb_valid = 1, then assert flush for one cycle. Next cycle expect cdb_valid = 0, all buffers empty, and no stale index broadcast afterwards. The next accept from requester 2 is granted first after rr_ptr resets to 0.
- Async reset mid-stream: drop rst between edges while results are pending. Expect cdb_valid = 0 immediately, and no pending result appears after rst returns to 1.
